// File: rtl/input_conditioner.sv
// Per-pin synchroniser and debouncer for the MC14500B wrapper inputs.
// Emits debounced levels, one-cycle rise/fall pulses and sticky event flags.
module input_conditioner #(
  parameter int INPUT_SIZE      = 5,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INPUT_SIZE-1:0] raw_pins,
  input  logic                  tick,
  input  logic [INPUT_SIZE-1:0] clear_events,
  output logic [INPUT_SIZE-1:0] clean_pins,
  output logic [INPUT_SIZE-1:0] rise,
  output logic [INPUT_SIZE-1:0] fall,
  output logic [INPUT_SIZE-1:0] events
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [INPUT_SIZE-1:0] s0;
  logic [INPUT_SIZE-1:0] s1;
  logic [INPUT_SIZE-1:0] stable;
  logic [INPUT_SIZE-1:0] mismatch;
  logic [INPUT_SIZE-1:0] commit;
  logic [CNT_WIDTH-1:0]  cnt     [INPUT_SIZE];
  logic [CNT_WIDTH-1:0]  cnt_nxt [INPUT_SIZE];

  // A commit only happens on a mismatch, so toggling stable lands it on s1.
  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      mismatch[i] = s1[i] ^ stable[i];
      commit[i]   = mismatch[i] & tick & (cnt[i] == CNT_LAST);
      cnt_nxt[i]  = cnt[i];
      if (!mismatch[i])
        cnt_nxt[i] = '0;
      else if (tick) begin
        if (commit[i])
          cnt_nxt[i] = '0;
        else
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0     <= '0;
      s1     <= '0;
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      events <= '0;
      for (int i = 0; i < INPUT_SIZE; i++)
        cnt[i] <= '0;
    end else begin
      s0     <= raw_pins;
      s1     <= s0;
      stable <= stable ^ commit;
      rise   <= commit & s1;
      fall   <= commit & ~s1;
      // Set wins over a same-cycle clear.
      events <= commit | (events & ~clear_events);
      for (int i = 0; i < INPUT_SIZE; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  assign clean_pins = stable;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected rise/fall pulses are queued
// with their pin, direction and cycle; a monitor pops them as pulses appear.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] raw_pins = '0;
  logic       tick = 1'b1;
  logic [4:0] clear_events = '0;
  logic [4:0] clean_pins, rise, fall, events;

  input_conditioner #(.INPUT_SIZE(5), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .raw_pins(raw_pins), .tick(tick),
    .clear_events(clear_events), .clean_pins(clean_pins), .rise(rise),
    .fall(fall), .events(events)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pin;
    bit rising;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int pin, input bit rising, input int at);
    exp_t e;
    e.pin = pin; e.rising = rising; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rise[i] | fall[i]) begin
        checks++;
        if (rise[i] & fall[i]) begin
          failures++;
          $display("FAIL pulse_both: pin %0d rise and fall high at cycle %0d", i, cyc);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: pin %0d rise=%0b at cycle %0d, none expected", i, rise[i], cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.pin != i || e.rising != rise[i] || e.cyc != cyc) begin
            failures++;
            $display("FAIL pulse: got pin %0d rise=%0b cycle %0d expected pin %0d rise=%0b cycle %0d",
                     i, rise[i], cyc, e.pin, e.rising, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int base;

    // Reset held with all pins high: everything stays 0.
    raw_pins = 5'b11111;
    repeat (4) @(negedge clk);
    chk("reset_clean", clean_pins, 5'b00000);
    chk("reset_rise", rise, 5'b00000);
    chk("reset_fall", fall, 5'b00000);
    chk("reset_events", events, 5'b00000);

    // Pins high through release commit via the normal path at edge 9.
    reset = 1'b1;
    base = cyc;
    for (int p = 0; p < 5; p++) push(p, 1'b1, base + 10);
    repeat (9) @(negedge clk);
    chk("release_before_edge9", clean_pins, 5'b00000);
    @(negedge clk);
    chk("release_commit", clean_pins, 5'b11111);
    chk("release_events", events, 5'b11111);

    // Fresh reset with all pins low: nothing should ever commit.
    reset = 1'b0;
    raw_pins = 5'b00000;
    @(negedge clk);
    chk("reset_async_clear", clean_pins | events, 5'b00000);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_clean", clean_pins, 5'b00000);

    // Clean rise on pin 0.
    raw_pins = 5'b00001;
    base = cyc;
    push(0, 1'b1, base + 10);
    repeat (9) @(negedge clk);
    chk("rise_before", clean_pins, 5'b00000);
    @(negedge clk);
    chk("rise_clean", clean_pins, 5'b00001);
    chk("rise_pulse", rise, 5'b00001);
    @(negedge clk);
    chk("rise_pulse_gone", rise, 5'b00000);
    chk("rise_events", events, 5'b00001);

    // Bounce on pin 2: high 5, low 3, then high for good.
    raw_pins[2] = 1'b1;
    repeat (5) @(negedge clk);
    raw_pins[2] = 1'b0;
    repeat (3) @(negedge clk);
    raw_pins[2] = 1'b1;
    base = cyc;
    push(2, 1'b1, base + 10);
    repeat (9) @(negedge clk);
    chk("bounce_hold", clean_pins, 5'b00001);
    @(negedge clk);
    chk("bounce_commit", clean_pins, 5'b00101);
    repeat (3) @(negedge clk);

    // Commit pin 3 high, then let it fall with tick high one cycle in four.
    raw_pins[3] = 1'b1;
    base = cyc;
    push(3, 1'b1, base + 10);
    repeat (12) @(negedge clk);
    chk("pin3_high", clean_pins, 5'b01101);
    raw_pins[3] = 1'b0;
    base = cyc;
    push(3, 1'b0, base + 32);
    for (int n = 0; n < 36; n++) begin
      tick = (n % 4 == 3);
      @(negedge clk);
      if (n == 30) chk("tick_before", clean_pins, 5'b01101);
      if (n == 31) chk("tick_fall", fall, 5'b01000);
      if (n == 32) chk("tick_fall_gone", fall, 5'b00000);
    end
    tick = 1'b1;
    chk("tick_clean", clean_pins, 5'b00101);

    // Event clear, then clear colliding with a new commit on pin 1.
    raw_pins[1] = 1'b1;
    base = cyc;
    push(1, 1'b1, base + 10);
    repeat (12) @(negedge clk);
    chk("ev1_set", events, 5'b01111);
    clear_events = 5'b00010;
    @(negedge clk);
    clear_events = 5'b00000;
    chk("ev1_cleared", events, 5'b01101);
    raw_pins[1] = 1'b0;
    base = cyc;
    push(1, 1'b0, base + 10);
    repeat (9) @(negedge clk);
    clear_events = 5'b00010;
    @(negedge clk);
    clear_events = 5'b00000;
    chk("ev1_collision", events, 5'b01111);
    repeat (3) @(negedge clk);

    // Independent pins: pin 4 rises, pin 0 falls three cycles later.
    raw_pins[4] = 1'b1;
    base = cyc;
    push(4, 1'b1, base + 10);
    repeat (3) @(negedge clk);
    raw_pins[0] = 1'b0;
    base = cyc;
    push(0, 1'b0, base + 10);
    repeat (15) @(negedge clk);
    chk("indep_clean", clean_pins, 5'b10100);

    // Reset with pin 0 at count 5 discards the pending change.
    raw_pins[0] = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_clean", clean_pins, 5'b00000);
    chk("midreset_events", events, 5'b00000);
    chk("midreset_pulses", rise | fall, 5'b00000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = cyc;
    push(0, 1'b1, base + 10);
    push(2, 1'b1, base + 10);
    push(4, 1'b1, base + 10);
    repeat (9) @(negedge clk);
    chk("recount_before", clean_pins, 5'b00000);
    @(negedge clk);
    chk("recount_commit", clean_pins, 5'b10101);
    repeat (4) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the MC14500B wrapper's `input_pins` bus. It double-synchronises each raw external input into the `clk` domain and debounces it. It presents a clean, glitch-free level per pin that feeds the wrapper's input port directly. It also emits per-pin one-cycle rise/fall pulses and sticky change flags, so supervisory logic can detect input events without polling every cycle.

## Interface
Parameters:
- `INPUT_SIZE`, default 5: number of conditioned pins; must match the wrapper's `INPUT_SIZE`.
- `DEBOUNCE_CYCLES`, default 8: number of qualifying `tick` cycles a new level must persist before commit; legal range 1..255.
- `CNT_WIDTH`, default 8: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `raw_pins` in INPUT_SIZE: unsynchronised external inputs.
- `tick` in 1: debounce sample enable; tie high to count every clock.
- `clear_events` in INPUT_SIZE: per-pin clear for `events`, sampled each cycle.
- `clean_pins` out INPUT_SIZE: debounced levels; connect to the wrapper's `input_pins`.
- `rise` out INPUT_SIZE: one-cycle pulse when the pin's `clean_pins` bit commits 0->1.
- `fall` out INPUT_SIZE: one-cycle pulse when the pin's `clean_pins` bit commits 1->0.
- `events` out INPUT_SIZE: sticky flag set on any commit of that pin.

## Operation
- Each pin is fully independent: a two-flop synchroniser `s0`/`s1`, a `stable` register driving `clean_pins`, and a CNT_WIDTH-bit counter `cnt`.
- Per pin, every clock edge:
  - **Match:** if `s1 == stable`, then `cnt <= 0`. Any pending change is abandoned.
  - **Mismatch, `tick`=0:** if `s1 != stable` and `tick`=0, `cnt` holds.
  - **Mismatch, counting:** if `s1 != stable`, `tick`=1 and `cnt < DEBOUNCE_CYCLES-1`, then `cnt <= cnt+1`.
  - **Mismatch, commit:** if `s1 != stable`, `tick`=1 and `cnt == DEBOUNCE_CYCLES-1`, then:
    - `stable <= s1` and `cnt <= 0`;
    - `rise` (or `fall`) is asserted for exactly the next cycle;
    - the pin's `events` bit is set.
- `rise`/`fall` are registered. Both are 0 in every cycle without a commit. They are never both high for the same pin.
- `events[i]` is set by a commit and cleared by `clear_events[i]`=1. On a simultaneous commit and clear, set wins and `events[i]` stays 1.
- A bounce that returns to the committed level before the count completes produces no output change, no pulse and no event.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- With DEBOUNCE_CYCLES=1, the first qualifying mismatch cycle commits.

## Timing
- Reset asserted: every register is cleared asynchronously, so `s0`, `s1`, `stable`, `cnt`, `clean_pins`, `rise`, `fall` and `events` all read 0. They remain 0 while `reset`=0.
- Reset mid-count discards the pending change; counting restarts from 0 after release.
- A pin held high through reset release commits to 1 via the normal path and raises `rise` and `events`.
- Latency with `tick` tied high:
  - a raw level stable before edge 0 is captured in `s0` at edge 0 and in `s1` at edge 1;
  - edges 2..DEBOUNCE_CYCLES+1 are the qualifying edges;
  - `clean_pins` changes after edge DEBOUNCE_CYCLES+1 (edge 9 for the default of 8);
  - `rise`/`fall` are high in the same cycle that `clean_pins` first shows the new value.
- With a gated `tick`, latency is 2 clocks plus DEBOUNCE_CYCLES edges on which `tick`=1.
- `clear_events` takes effect at the next clock edge, so `events` reads 0 in the following cycle.
- No combinational path exists from any input to any output.

## Test plan
- **Reset values:** hold `reset`=0 with `raw_pins`=5'b11111 -> all outputs 0; after release, nothing changes before edge 9.
- **Clean rise:** release reset, `tick`=1, `raw_pins` 5'b00000 -> 5'b00001 before edge 0 -> `clean_pins`=5'b00001 after edge 9; `rise`=5'b00001 for exactly one cycle; `events`=5'b00001; `fall`=0 throughout.
- **Bounce rejection:**
  - pin 2 high for 5 cycles, low for 3, then high permanently -> no change during the bounce;
  - `clean_pins[2]` rises 9 edges after the final transition;
  - exactly one `rise[2]` pulse.
- **Tick gating:**
  - `tick` high one cycle in four with pin 3 falling from a committed 1 -> `clean_pins[3]` falls only after 8 `tick`-high edges following `s1` update;
  - `fall[3]` is a single-clock pulse.
- **Event clear collision:**
  - `events[1]`=1, then `clear_events[1]`=1 -> 0 next cycle;
  - repeat with `clear_events[1]` asserted on the same edge as a new commit -> `events[1]` stays 1.
- **Reset mid-count and independence:**
  - pins 0 and 4 toggle at different times -> each commits per its own count;
  - assert `reset` at count 5 on pin 0 -> all outputs 0 immediately;
  - after release, full count again before commit.
